bmem_responder: RTL

- Burst-memory responder: the far end of the CPU cache unit's bmem port.
- Accepts 32-byte cacheline read and write requests and queues them in order.
- Commits writes to a line-wide backing array.
- Returns each read as 4 x 64-bit beats after a fixed latency.
- Synthesizable; serves as the memory model for core-level simulation and FPGA bring-up.

---
 rtl/bmem_responder_pkg.sv | 25 ++
 rtl/bmem_cmd_fifo.sv | 55 +++++
 rtl/bmem_responder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/bmem_responder_pkg.sv
// Shared types for the burst-memory responder: command entry layout,
// service FSM states and line/beat geometry.
package bmem_responder_pkg;

  localparam int unsigned BMEM_BEATS     = 4;
  localparam int unsigned BMEM_LINE_BITS = 256;
  localparam int unsigned BMEM_BEAT_BITS = 64;

  typedef struct packed {
    logic                      wr;
    logic [31:0]               addr;
    logic [BMEM_LINE_BITS-1:0] data;
  } bmem_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } bmem_rsp_state_t;

  function automatic logic [31:0] bmem_line_addr(input logic [31:0] a);
    return {a[31:5], 5'b0};
  endfunction

endpackage

// File: rtl/bmem_cmd_fifo.sv
// In-order command queue for the responder; pointers wrap modulo DEPTH,
// full/empty are derived from an occupancy count one bit wider than the pointers.
module bmem_cmd_fifo
  import bmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  bmem_cmd_t                i_cmd,
  input  logic                     i_pop,
  output bmem_cmd_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  bmem_cmd_t       r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_cmd;
  end

endmodule

// File: rtl/bmem_responder.sv
// Burst-memory responder: queues 32-byte line reads/writes in order, commits
// writes to a line-wide array and returns reads as 4 x 64-bit beats.
// Optional random request stalls: define BMEM_RESP_BACKPRESSURE_EN.
module bmem_responder
  import bmem_responder_pkg::*;
#(
  parameter int unsigned LINE_IDX_BITS = 10,
  parameter int unsigned QDEPTH        = 4,
  parameter int unsigned LATENCY       = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               bmem_addr,
  input  logic                      bmem_read,
  input  logic                      bmem_write,
  input  logic [BMEM_BEAT_BITS-1:0] bmem_wdata,
  output logic                      bmem_ready,
  output logic [31:0]               bmem_raddr,
  output logic [BMEM_BEAT_BITS-1:0] bmem_rdata,
  output logic                      bmem_rvalid
);

  localparam int unsigned LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic                        r_rst_n_q;

  logic                        r_asm;
  logic [1:0]                  r_asm_beat;
  logic [31:0]                 r_asm_addr;
  logic [3*BMEM_BEAT_BITS-1:0] r_asm_data;

  logic [BMEM_LINE_BITS-1:0]   r_array [2**LINE_IDX_BITS];

  bmem_rsp_state_t             r_state;
  logic [LW-1:0]               r_lat_cnt;
  logic [2:0]                  r_beat;
  logic [BMEM_LINE_BITS-1:0]   r_line;
  logic                        r_rvalid;
  logic [31:0]                 r_raddr;
  logic [BMEM_BEAT_BITS-1:0]   r_rdata;

  logic                        w_accept;
  logic                        w_rd_accept;
  logic                        w_wr_accept;
  logic                        w_asm_last;
  logic                        w_push;
  bmem_cmd_t                   w_push_cmd;
  logic                        w_pop;
  bmem_cmd_t                   w_head;
  logic [$clog2(QDEPTH):0]     w_count;
  logic                        w_full;
  logic                        w_empty;
  logic [LINE_IDX_BITS-1:0]    w_head_idx;
  logic [BMEM_LINE_BITS-1:0]   w_rd_line;
  logic                        w_commit;
  logic                        w_burst_done;
  logic                        w_room;
  logic                        w_bp_ok;

`ifdef BMEM_RESP_BACKPRESSURE_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  assign w_bp_ok = (r_lfsr[1:0] != 2'b00);
`else
  assign w_bp_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    r_rst_n_q <= rst_n;
  end

  // An in-flight write assembly holds a slot so its push after beat 3 always fits.
  assign w_room     = (32'(w_count) + 32'(r_asm)) < QDEPTH;
  assign bmem_ready = r_rst_n_q & w_room & ~w_full & ~r_asm & w_bp_ok;

  assign w_accept    = (bmem_read | bmem_write) & bmem_ready;
  assign w_rd_accept = w_accept & bmem_read;
  assign w_wr_accept = w_accept & bmem_write & ~bmem_read;
  assign w_asm_last  = r_asm & (r_asm_beat == 2'd3);
  assign w_push      = w_rd_accept | w_asm_last;

  always_comb begin
    w_push_cmd = '0;
    if (w_asm_last) begin
      w_push_cmd.wr   = 1'b1;
      w_push_cmd.addr = r_asm_addr;
      w_push_cmd.data = {bmem_wdata, r_asm_data};
    end else begin
      w_push_cmd.wr   = 1'b0;
      w_push_cmd.addr = bmem_line_addr(bmem_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_asm      <= 1'b0;
      r_asm_beat <= '0;
      r_asm_addr <= '0;
      r_asm_data <= '0;
    end else if (r_asm) begin
      case (r_asm_beat)
        2'd1:    r_asm_data[2*BMEM_BEAT_BITS-1:BMEM_BEAT_BITS]   <= bmem_wdata;
        2'd2:    r_asm_data[3*BMEM_BEAT_BITS-1:2*BMEM_BEAT_BITS] <= bmem_wdata;
        default: ;
      endcase
      r_asm_beat <= r_asm_beat + 2'd1;
      if (w_asm_last) r_asm <= 1'b0;
    end else if (w_wr_accept) begin
      r_asm                          <= 1'b1;
      r_asm_beat                     <= 2'd1;
      r_asm_addr                     <= bmem_line_addr(bmem_addr);
      r_asm_data[BMEM_BEAT_BITS-1:0] <= bmem_wdata;
    end
  end

  bmem_cmd_fifo #(
    .DEPTH(QDEPTH)
  ) u_cmd_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_cmd   (w_push_cmd),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head_idx   = w_head.addr[5 +: LINE_IDX_BITS];
  assign w_rd_line    = r_array[w_head_idx];
  assign w_commit     = rst_n & (r_state == IDLE) & ~w_empty & w_head.wr;
  assign w_burst_done = (r_state == BURST) & (r_beat == 3'd4);
  assign w_pop        = w_commit | w_burst_done;

  always_ff @(posedge clk) begin
    if (w_commit) r_array[w_head_idx] <= w_head.data;
  end

  // Beat 0 leaves with the array read; later beats shift down out of r_line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_beat    <= '0;
      r_line    <= '0;
      r_rvalid  <= 1'b0;
      r_raddr   <= '0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_rvalid <= 1'b0;
          if (!w_empty && !w_head.wr) begin
            r_state   <= WAIT;
            r_lat_cnt <= LW'(LATENCY - 1);
          end
        end
        WAIT: begin
          if (r_lat_cnt == '0) begin
            r_line   <= w_rd_line;
            r_rdata  <= w_rd_line[BMEM_BEAT_BITS-1:0];
            r_raddr  <= w_head.addr;
            r_rvalid <= 1'b1;
            r_beat   <= 3'd1;
            r_state  <= BURST;
          end else begin
            r_lat_cnt <= r_lat_cnt - LW'(1);
          end
        end
        BURST: begin
          if (r_beat == 3'd4) begin
            r_rvalid <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_rdata <= r_line[2*BMEM_BEAT_BITS-1:BMEM_BEAT_BITS];
            r_line  <= {{BMEM_BEAT_BITS{1'b0}}, r_line[BMEM_LINE_BITS-1:BMEM_BEAT_BITS]};
            r_beat  <= r_beat + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bmem_rvalid = r_rvalid;
  assign bmem_raddr  = r_raddr;
  assign bmem_rdata  = r_rdata;

endmodule
